// File: rtl/g2b_pkg.sv
// Shared definitions for the Gray-to-binary tracker: FSM encodings and defaults.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package g2b_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    TRACK  = 2'd1,
    ERROR  = 2'd2
  } g2b_state_t;

  localparam int G2B_WIDTH       = 4;
  localparam int G2B_SYNC_STAGES = 2;

  // True when exactly one bit of v is set (a legal single-bit Gray step).
  function automatic logic is_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/gray_to_binary_comb.sv
// Pure combinational Gray-to-binary decode (XOR of all Gray bits at or above each position).
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows input continuously.
module gray_to_binary_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the parity of the Gray bits from the MSB down to that bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/graycode_to_binary_tracker.sv
// Synchronises an asynchronous Gray count, decodes it, tracks step direction and flags multi-bit steps.
// Latency: SYNC_STAGES+1 edges from gray_in to binary_out/bin_valid (+1 with G2B_OUTPUT_PIPE_EN).
// Backpressure: none; input is sampled every cycle and bin_valid is a free-running pulse.
module graycode_to_binary_tracker
  import g2b_pkg::*;
#(
  parameter int WIDTH       = G2B_WIDTH,
  parameter int SYNC_STAGES = G2B_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] binary_out,
  output logic             bin_valid,
  output logic             dir_up,
  output logic             locked,
  output logic             step_err
);

  localparam int CW = $clog2(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] g_bin;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_q;
  logic             vld_q;
  logic             dir_q;
  logic             lock_q;
  logic             err_q;
  logic [CW-1:0]    warm_cnt;
  logic             warm_last;
  logic             step_one;
  logic             step_multi;
  logic             do_load;
  logic             do_upd;
  logic             set_err;
  logic             clr_err;
  g2b_state_t       state;
  g2b_state_t       state_nxt;

  // Multi-flop synchroniser bringing the asynchronous Gray value into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
    end else begin
      sync[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  assign g = sync[SYNC_STAGES-1];

  gray_to_binary_comb #(.WIDTH(WIDTH)) u_dec (
    .gray (g),
    .bin  (g_bin)
  );

  assign d          = g ^ gray_q;
  assign step_one   = is_one_hot(32'(d));
  assign step_multi = (d != '0) && !step_one;
  assign warm_last  = (warm_cnt == CW'(SYNC_STAGES - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WARMUP;
    else        state <= state_nxt;
  end

  // Next state: warm-up until the synchroniser is full, then track; multi-bit steps trap in ERROR.
  always_comb begin
    state_nxt = state;
    case (state)
      WARMUP:  if (warm_last) state_nxt = TRACK;
      TRACK:   if (step_multi) state_nxt = ERROR;
      ERROR:   if (err_clr && !step_multi) state_nxt = TRACK;
      default: state_nxt = WARMUP;
    endcase
  end

  // FSM outputs: datapath enables; a new multi-bit step beats a coincident err_clr.
  always_comb begin
    do_load = 1'b0;
    do_upd  = 1'b0;
    set_err = 1'b0;
    clr_err = 1'b0;
    case (state)
      WARMUP: do_load = warm_last;
      TRACK: begin
        do_upd  = (d != '0);
        set_err = step_multi;
      end
      ERROR: begin
        do_upd  = (d != '0);
        set_err = step_multi;
        clr_err = err_clr && !step_multi;
      end
      default: ;
    endcase
  end

  // Tracking registers: last accepted Gray value, decoded binary, direction, lock and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt <= '0;
      gray_q   <= '0;
      bin_q    <= '0;
      vld_q    <= 1'b0;
      dir_q    <= 1'b0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vld_q <= do_upd;
      if (state == WARMUP && !warm_last) warm_cnt <= warm_cnt + CW'(1);
      if (do_load) begin
        gray_q <= g;
        bin_q  <= g_bin;
        lock_q <= 1'b1;
      end
      if (do_upd) begin
        gray_q <= g;
        bin_q  <= g_bin;
        if (step_one) dir_q <= (g_bin == bin_q + WIDTH'(1));
      end
      if (set_err)      err_q <= 1'b1;
      else if (clr_err) err_q <= 1'b0;
    end
  end

`ifdef G2B_OUTPUT_PIPE_EN
  // Extra output register stage; locked and step_err ride along to stay aligned with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binary_out <= '0;
      bin_valid  <= 1'b0;
      dir_up     <= 1'b0;
      locked     <= 1'b0;
      step_err   <= 1'b0;
    end else begin
      binary_out <= bin_q;
      bin_valid  <= vld_q;
      dir_up     <= dir_q;
      locked     <= lock_q;
      step_err   <= err_q;
    end
  end
`else
  assign binary_out = bin_q;
  assign bin_valid  = vld_q;
  assign dir_up     = dir_q;
  assign locked     = lock_q;
  assign step_err   = err_q;
`endif

endmodule

// File: tb/tb_graycode_to_binary_tracker.sv
module tb_graycode_to_binary_tracker;

  localparam int W = 4;
  localparam int S = 2;
`ifdef G2B_OUTPUT_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  localparam int LAT = S + 1 + PIPE;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] gray_in;
  logic         err_clr;
  logic [W-1:0] binary_out;
  logic         bin_valid;
  logic         dir_up;
  logic         locked;
  logic         step_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] cur;

  graycode_to_binary_tracker #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_in    (gray_in),
    .err_clr    (err_clr),
    .binary_out (binary_out),
    .bin_valid  (bin_valid),
    .dir_up     (dir_up),
    .locked     (locked),
    .step_err   (step_err)
  );

  wire [7:0] obs = {binary_out, bin_valid, dir_up, locked, step_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (behavioural) ----------------
  logic [W-1:0] ghist [$];
  logic [W-1:0] m_gq, m_bin;
  logic         m_vld, m_dir, m_lock, m_err;
  int           m_cnt;
  logic [7:0]   p_vec;

  function automatic logic [W-1:0] gdec(input logic [W-1:0] gv);
    for (int b = 0; b < (1 << W); b++)
      if (W'(b ^ (b >> 1)) == gv) return W'(b);
    return '0;
  endfunction

  function automatic logic [W-1:0] genc(input int n);
    return W'(n ^ (n >> 1));
  endfunction

  function automatic logic [7:0] core_vec();
    return {m_bin, m_vld, m_dir, m_lock, m_err};
  endfunction

  function automatic logic [7:0] exp_vec();
    return (PIPE != 0) ? p_vec : core_vec();
  endfunction

  task automatic model_reset();
    ghist.delete();
    for (int i = 0; i < S; i++) ghist.push_back('0);
    m_gq = '0; m_bin = '0; m_vld = 0; m_dir = 0; m_lock = 0; m_err = 0;
    m_cnt = 0; p_vec = '0;
  endtask

  task automatic model_edge();
    logic [W-1:0] gv, nb;
    int nd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    p_vec = core_vec();
    ghist.push_back(gray_in);
    gv = ghist.pop_front();
    m_vld = 0;
    if (!m_lock) begin
      m_cnt++;
      if (m_cnt == S) begin
        m_lock = 1; m_gq = gv; m_bin = gdec(gv);
      end
    end else begin
      nd = $countones(gv ^ m_gq);
      if (nd > 0) begin
        nb = gdec(gv);
        if (nd == 1) m_dir = (nb == W'(m_bin + 1));
        m_bin = nb; m_gq = gv; m_vld = 1;
      end
      if (nd >= 2) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  endtask

  task automatic tick(input logic [W-1:0] gi, input logic clr);
    @(negedge clk);
    gray_in = gi;
    err_clr = clr;
    cur = gi;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      tick('0, 1'b0);
      n_checks++;
      if (obs !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_hold: got %h want 00", obs);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick('0, 1'b0);
      n_checks++;
      if (locked !== (k >= S + PIPE)) begin
        n_errors++;
        $display("FAIL warmup_lock k=%0d: got %b want %b", k, locked, (k >= S + PIPE));
      end
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL warmup_model k=%0d: got %h want %h", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_count_up();
    logic [W-1:0] seq [4];
    seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
    for (int s = 0; s < 4; s++) begin
      for (int j = 1; j <= 4; j++) begin
        tick(seq[s], 1'b0);
        n_checks++;
        if (bin_valid !== (j == LAT)) begin
          n_errors++;
          $display("FAIL count_up_pulse s=%0d j=%0d: got %b want %b", s, j, bin_valid, (j == LAT));
        end
        n_checks++;
        if (obs !== exp_vec()) begin
          n_errors++;
          $display("FAIL count_up_model s=%0d j=%0d: got %h want %h", s, j, obs, exp_vec());
        end
      end
      n_checks++;
      if (binary_out !== W'(s + 1) || dir_up !== 1'b1) begin
        n_errors++;
        $display("FAIL count_up_value s=%0d: got bin=%0d dir=%b want bin=%0d dir=1",
                 s, binary_out, dir_up, s + 1);
      end
    end
  endtask

  task automatic test_wrap();
    for (int n = 5; n <= 17; n++) begin
      logic [W-1:0] gv;
      gv = (n == 16) ? 4'b0000 : (n == 17) ? 4'b1000 : genc(n);
      for (int j = 0; j < 5; j++) begin
        tick(gv, 1'b0);
        n_checks++;
        if (obs !== exp_vec()) begin
          n_errors++;
          $display("FAIL wrap_model n=%0d j=%0d: got %h want %h", n, j, obs, exp_vec());
        end
      end
      if (n == 16) begin
        n_checks++;
        if (binary_out !== 4'd0 || dir_up !== 1'b1) begin
          n_errors++;
          $display("FAIL wrap_15_to_0: got bin=%0d dir=%b want bin=0 dir=1", binary_out, dir_up);
        end
      end
      if (n == 17) begin
        n_checks++;
        if (binary_out !== 4'd15 || dir_up !== 1'b0) begin
          n_errors++;
          $display("FAIL wrap_0_to_15: got bin=%0d dir=%b want bin=15 dir=0", binary_out, dir_up);
        end
      end
    end
  endtask

  task automatic test_error();
    // return to 0000 (single-bit from 1000, dir_up=1)
    for (int j = 0; j < 5; j++) tick(4'b0000, 1'b0);
    // multi-bit jump 0000 -> 0011
    for (int j = 1; j <= 5; j++) begin
      tick(4'b0011, 1'b0);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL err_jump_model j=%0d: got %h want %h", j, obs, exp_vec());
      end
    end
    n_checks++;
    if (step_err !== 1'b1 || binary_out !== 4'd2 || dir_up !== 1'b1) begin
      n_errors++;
      $display("FAIL err_jump: got err=%b bin=%0d dir=%b want err=1 bin=2 dir=1",
               step_err, binary_out, dir_up);
    end
    // err_clr pulse clears
    tick(4'b0011, 1'b1);
    for (int j = 0; j < 3; j++) tick(4'b0011, 1'b0);
    n_checks++;
    if (step_err !== 1'b0 || obs !== exp_vec()) begin
      n_errors++;
      $display("FAIL err_clear: got %h err=%b want %h err=0", obs, step_err, exp_vec());
    end
    // 0011 -> 0101 then 0101 -> 0000, err_clr on the edge that sees each jump
    for (int p = 0; p < 2; p++) begin
      logic [W-1:0] gv;
      gv = (p == 0) ? 4'b0101 : 4'b0000;
      for (int j = 1; j <= 6; j++) begin
        tick(gv, (j == S + 1));
        n_checks++;
        if (obs !== exp_vec()) begin
          n_errors++;
          $display("FAIL err_coincident_model p=%0d j=%0d: got %h want %h", p, j, obs, exp_vec());
        end
      end
      n_checks++;
      if (step_err !== 1'b1 || binary_out !== gdec(gv)) begin
        n_errors++;
        $display("FAIL err_coincident p=%0d: got err=%b bin=%0d want err=1 bin=%0d",
                 p, step_err, binary_out, gdec(gv));
      end
    end
    tick(4'b0000, 1'b1);
    for (int j = 0; j < 3; j++) tick(4'b0000, 1'b0);
    n_checks++;
    if (step_err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_final_clear: got err=%b want 0", step_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] seq [5];
    seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
    for (int s = 0; s < 5; s++)
      for (int j = 0; j < 5; j++) tick(seq[s], 1'b0);
    n_checks++;
    if (binary_out !== 4'd5) begin
      n_errors++;
      $display("FAIL mid_before: got bin=%0d want 5", binary_out);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs !== 8'h00) begin
      n_errors++;
      $display("FAIL mid_async_reset: got %h want 00", obs);
    end
    for (int j = 0; j < 3; j++) begin
      tick(4'b0111, 1'b0);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL mid_reset_hold j=%0d: got %h want %h", j, obs, exp_vec());
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(4'b0111, 1'b0);
      n_checks++;
      if (locked !== (k >= S + PIPE)) begin
        n_errors++;
        $display("FAIL mid_relock k=%0d: got %b want %b", k, locked, (k >= S + PIPE));
      end
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL mid_relock_model k=%0d: got %h want %h", k, obs, exp_vec());
      end
    end
    n_checks++;
    if (binary_out !== 4'd5) begin
      n_errors++;
      $display("FAIL mid_after: got bin=%0d want 5", binary_out);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] nxt, m;
    int r, hold;
    tick(cur, 1'b1);
    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 9);
      nxt = cur;
      if (r < 7) begin
        nxt = cur ^ W'(1 << $urandom_range(0, W - 1));
      end else if (r < 9) begin
        m = W'($urandom_range(1, (1 << W) - 1));
        while ($countones(m) < 2) m = W'($urandom_range(1, (1 << W) - 1));
        nxt = cur ^ m;
      end
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        tick(nxt, ($urandom_range(0, 7) == 0));
        n_checks++;
        if (obs !== exp_vec()) begin
          n_errors++;
          $display("FAIL random it=%0d h=%0d: got %h want %h", it, h, obs, exp_vec());
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    gray_in = '0;
    err_clr = 1'b0;
    cur     = '0;
    model_reset();
    test_reset();
    test_count_up();
    test_wrap();
    test_error();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
